// File: rtl/multicycle_fsm_pkg.sv
// multicycle_fsm_pkg -- shared definitions for the multicycle control FSM.
//
// Holds the 4-bit state enumeration, the opcode constants, the ALUOp and
// mux-select encodings, the bundled control-output struct and an opcode
// legality helper.
//
// Configuration macro: MULTICYCLE_FSM_JALR_EN. When it is defined, jalr
// (op 1100111) counts as a supported opcode. When it is not defined, jalr is
// treated as illegal.
package multicycle_fsm_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_JALR1    = 4'd11,
        S_JALR2    = 4'd12
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic ADR_PC     = 1'b0;
    localparam logic ADR_ALUOUT = 1'b1;

`ifdef MULTICYCLE_FSM_JALR_EN
    localparam bit JALR_ENABLED = 1'b1;
`else
    localparam bit JALR_ENABLED = 1'b0;
`endif

    // Control word for one state. The illegal pulse is not part of this
    // word because it depends on op as well as on the state.
    typedef struct packed {
        logic       branch;
        logic       pcUpdate;
        logic       regWrite;
        logic       memWrite;
        logic       irWrite;
        logic [1:0] resultSrc;
        logic [1:0] aluSrcA;
        logic [1:0] aluSrcB;
        logic       adrSrc;
        logic [1:0] aluOp;
        logic       instrDone;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

    // Returns true for every opcode that DECODE dispatches to an execution
    // sequence. Any other opcode returns to FETCH and raises the illegal flag.
    function automatic logic isLegalOp(input logic [6:0] opcode);
        return (opcode == OP_LOAD)  || (opcode == OP_STORE) ||
               (opcode == OP_RTYPE) || (opcode == OP_ITYPE) ||
               (opcode == OP_JAL)   || (opcode == OP_BEQ)   ||
               (JALR_ENABLED && (opcode == OP_JALR));
    endfunction

endpackage

// File: rtl/multicycle_fsm_outdec.sv
// multicycle_fsm_outdec -- Moore output decoder for the multicycle control FSM.
//
// Ports:
//   state_i  current FSM state
//   ctrl_o   control word for that state (all fields 0 for unreachable codes)
module multicycle_fsm_outdec
    import multicycle_fsm_pkg::*;
(
    input  state_t state_i,
    output ctrl_t  ctrl_o
);

    // Each state drives only the fields it uses. All other fields keep the
    // idle default of zero.
    always_comb begin
        ctrl_o = CTRL_IDLE;
        case (state_i)
            S_FETCH: begin
                ctrl_o.adrSrc    = ADR_PC;
                ctrl_o.irWrite   = 1'b1;
                ctrl_o.aluSrcA   = SRCA_PC;
                ctrl_o.aluSrcB   = SRCB_FOUR;
                ctrl_o.aluOp     = ALUOP_ADD;
                ctrl_o.resultSrc = RES_ALURESULT;
                ctrl_o.pcUpdate  = 1'b1;
            end
            S_DECODE: begin
                ctrl_o.aluSrcA = SRCA_OLDPC;
                ctrl_o.aluSrcB = SRCB_IMM;
                ctrl_o.aluOp   = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl_o.aluSrcA = SRCA_RS1;
                ctrl_o.aluSrcB = SRCB_IMM;
                ctrl_o.aluOp   = ALUOP_ADD;
            end
            S_MEMREAD: begin
                ctrl_o.resultSrc = RES_ALUOUT;
                ctrl_o.adrSrc    = ADR_ALUOUT;
            end
            S_MEMWB: begin
                ctrl_o.resultSrc = RES_DATA;
                ctrl_o.regWrite  = 1'b1;
                ctrl_o.instrDone = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl_o.resultSrc = RES_ALUOUT;
                ctrl_o.adrSrc    = ADR_ALUOUT;
                ctrl_o.memWrite  = 1'b1;
                ctrl_o.instrDone = 1'b1;
            end
            S_EXECR: begin
                ctrl_o.aluSrcA = SRCA_RS1;
                ctrl_o.aluSrcB = SRCB_RS2;
                ctrl_o.aluOp   = ALUOP_FUNCT;
            end
            S_EXECI: begin
                ctrl_o.aluSrcA = SRCA_RS1;
                ctrl_o.aluSrcB = SRCB_IMM;
                ctrl_o.aluOp   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl_o.resultSrc = RES_ALUOUT;
                ctrl_o.regWrite  = 1'b1;
                ctrl_o.instrDone = 1'b1;
            end
            S_JAL: begin
                ctrl_o.aluSrcA   = SRCA_OLDPC;
                ctrl_o.aluSrcB   = SRCB_FOUR;
                ctrl_o.aluOp     = ALUOP_ADD;
                ctrl_o.resultSrc = RES_ALUOUT;
                ctrl_o.pcUpdate  = 1'b1;
            end
            S_BEQ: begin
                ctrl_o.aluSrcA   = SRCA_RS1;
                ctrl_o.aluSrcB   = SRCB_RS2;
                ctrl_o.aluOp     = ALUOP_SUB;
                ctrl_o.resultSrc = RES_ALUOUT;
                ctrl_o.branch    = 1'b1;
                ctrl_o.instrDone = 1'b1;
            end
            S_JALR1: begin
                ctrl_o.aluSrcA = SRCA_RS1;
                ctrl_o.aluSrcB = SRCB_IMM;
                ctrl_o.aluOp   = ALUOP_ADD;
            end
            S_JALR2: begin
                ctrl_o.resultSrc = RES_ALUOUT;
                ctrl_o.pcUpdate  = 1'b1;
                ctrl_o.aluSrcA   = SRCA_OLDPC;
                ctrl_o.aluSrcB   = SRCB_FOUR;
                ctrl_o.aluOp     = ALUOP_ADD;
            end
            default: ctrl_o = CTRL_IDLE;
        endcase
    end

endmodule

// File: rtl/multicycle_fsm.sv
// multicycle_fsm -- Moore control FSM for a multicycle RISC-V style datapath.
//
// Ports:
//   clk         clock; the state register updates on the rising edge
//   reset       synchronous, active-high reset; forces FETCH and holds every
//               output at 0 while it is high
//   op[6:0]     opcode field of the instruction register
//   Branch      branch-qualify strobe
//   PCUpdate    unconditional PC write enable
//   RegWrite    register file write enable
//   MemWrite    data memory write enable
//   IRWrite     instruction register / OldPC load enable
//   ResultSrc   result mux select
//   ALUSrcA     ALU A mux select
//   ALUSrcB     ALU B mux select
//   AdrSrc      memory address select
//   ALUOp       ALU decoder control
//   instr_done  pulse in the final state of each instruction
//   illegal     pulse in DECODE when op is not supported
//
// Configuration macro: MULTICYCLE_FSM_JALR_EN. When it is defined, jalr is
// executed through JALR1 and JALR2.
module multicycle_fsm
    import multicycle_fsm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    output logic       Branch,
    output logic       PCUpdate,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       AdrSrc,
    output logic [1:0] ALUOp,
    output logic       instr_done,
    output logic       illegal
);

    state_t state_q;
    state_t state_d;
    ctrl_t  decCtrl;
    ctrl_t  outCtrl;
    logic   illegalRaw;

    // Next-state logic. Only DECODE and MEMADR look at op. Any unused state
    // code falls back to FETCH.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_JAL:            state_d = S_JAL;
                    OP_BEQ:            state_d = S_BEQ;
`ifdef MULTICYCLE_FSM_JALR_EN
                    OP_JALR:           state_d = S_JALR1;
`endif
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_BEQ:      state_d = S_FETCH;
            S_JALR1:    state_d = S_JALR2;
            S_JALR2:    state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // State register. Reset abandons any instruction in progress and
    // restarts at FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    multicycle_fsm_outdec u_outdec (
        .state_i (state_q),
        .ctrl_o  (decCtrl)
    );

    // Outputs are forced to zero while reset is high. The state register is
    // already FETCH during reset, so without this gate the FETCH write
    // enables would appear before reset is released.
    always_comb begin
        outCtrl    = reset ? CTRL_IDLE : decCtrl;
        illegalRaw = (state_q == S_DECODE) && !isLegalOp(op);
    end

    assign Branch     = outCtrl.branch;
    assign PCUpdate   = outCtrl.pcUpdate;
    assign RegWrite   = outCtrl.regWrite;
    assign MemWrite   = outCtrl.memWrite;
    assign IRWrite    = outCtrl.irWrite;
    assign ResultSrc  = outCtrl.resultSrc;
    assign ALUSrcA    = outCtrl.aluSrcA;
    assign ALUSrcB    = outCtrl.aluSrcB;
    assign AdrSrc     = outCtrl.adrSrc;
    assign ALUOp      = outCtrl.aluOp;
    assign instr_done = outCtrl.instrDone;
    assign illegal    = illegalRaw && !reset;

endmodule

// File: tb/tb_multicycle_fsm.sv
// tb_multicycle_fsm -- self-checking bench for multicycle_fsm.
//
// The reference model describes each instruction class as a list of named
// steps. Each step maps to the output values listed for it. The bench follows
// the MULTICYCLE_FSM_JALR_EN macro so that it matches the build under test.
module tb_multicycle_fsm;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic       Branch, PCUpdate, RegWrite, MemWrite, IRWrite, AdrSrc;
    logic       instr_done, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;

    int totalCount = 0;
    int badCount   = 0;

`ifdef MULTICYCLE_FSM_JALR_EN
    localparam bit TB_JALR = 1'b1;
`else
    localparam bit TB_JALR = 1'b0;
`endif

    typedef enum int {
        ST_FETCH, ST_DECODE, ST_DECODE_ILL, ST_MEMADR, ST_MEMREAD, ST_MEMWB,
        ST_MEMWRITE, ST_EXECR, ST_EXECI, ST_ALUWB, ST_JAL, ST_BEQ,
        ST_JALR1, ST_JALR2
    } step_e;

    multicycle_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .Branch     (Branch),
        .PCUpdate   (PCUpdate),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .AdrSrc     (AdrSrc),
        .ALUOp      (ALUOp),
        .instr_done (instr_done),
        .illegal    (illegal)
    );

    // Clock: 10 time units per period, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so that the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // All outputs observed in one cycle, packed in a fixed order.
    logic [15:0] actualVec;
    assign actualVec = {Branch, PCUpdate, RegWrite, MemWrite, IRWrite, ResultSrc,
                        ALUSrcA, ALUSrcB, AdrSrc, ALUOp, instr_done, illegal};

    // Builds an expected vector in the same order as actualVec.
    function automatic logic [15:0] mk(input logic br, input logic pcu, input logic rw,
                                       input logic mw, input logic irw, input logic [1:0] res,
                                       input logic [1:0] a, input logic [1:0] b, input logic adr,
                                       input logic [1:0] aop, input logic done, input logic ill);
        return {br, pcu, rw, mw, irw, res, a, b, adr, aop, done, ill};
    endfunction

    // Output values listed for each step. Anything not listed is zero.
    function automatic logic [15:0] stepVec(input step_e s);
        case (s)
            //                    br pcu rw mw irw res    A      B      adr aop   done ill
            ST_FETCH:      return mk(0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 0, 2'b00, 0, 0);
            ST_DECODE:     return mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, 2'b00, 0, 0);
            ST_DECODE_ILL: return mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, 2'b00, 0, 1);
            ST_MEMADR:     return mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 2'b00, 0, 0);
            ST_MEMREAD:    return mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 0, 0);
            ST_MEMWB:      return mk(0, 0, 1, 0, 0, 2'b01, 2'b00, 2'b00, 0, 2'b00, 1, 0);
            ST_MEMWRITE:   return mk(0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 1, 0);
            ST_EXECR:      return mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 2'b10, 0, 0);
            ST_EXECI:      return mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 2'b10, 0, 0);
            ST_ALUWB:      return mk(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 1, 0);
            ST_JAL:        return mk(0, 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 0, 2'b00, 0, 0);
            ST_BEQ:        return mk(1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 2'b01, 1, 0);
            ST_JALR1:      return mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 2'b00, 0, 0);
            ST_JALR2:      return mk(0, 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 0, 2'b00, 0, 0);
            default:       return 16'h0000;
        endcase
    endfunction

    // Number of cycles each instruction class takes.
    function automatic int latencyOf(input logic [6:0] o);
        case (o)
            7'b0000011: return 5;
            7'b0100011: return 4;
            7'b0110011: return 4;
            7'b0010011: return 4;
            7'b1101111: return 4;
            7'b1100011: return 3;
            7'b1100111: return TB_JALR ? 5 : 2;
            default:    return 2;
        endcase
    endfunction

    // Step that an instruction with opcode o should be in at cycle idx
    // (0 = FETCH).
    function automatic step_e stepAt(input logic [6:0] o, input int idx);
        step_e s[5];
        s = '{ST_FETCH, ST_DECODE_ILL, ST_FETCH, ST_FETCH, ST_FETCH};
        case (o)
            7'b0000011: s = '{ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMREAD, ST_MEMWB};
            7'b0100011: s = '{ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMWRITE, ST_FETCH};
            7'b0110011: s = '{ST_FETCH, ST_DECODE, ST_EXECR, ST_ALUWB, ST_FETCH};
            7'b0010011: s = '{ST_FETCH, ST_DECODE, ST_EXECI, ST_ALUWB, ST_FETCH};
            7'b1101111: s = '{ST_FETCH, ST_DECODE, ST_JAL, ST_ALUWB, ST_FETCH};
            7'b1100011: s = '{ST_FETCH, ST_DECODE, ST_BEQ, ST_FETCH, ST_FETCH};
            7'b1100111: if (TB_JALR) s = '{ST_FETCH, ST_DECODE, ST_JALR1, ST_JALR2, ST_ALUWB};
            default:    ;
        endcase
        return s[idx];
    endfunction

    // Drives the opcode for the next instruction. The caller must be part-way
    // through a cycle in which the DUT should be in FETCH.
    task automatic applyStimulus(input logic [6:0] o);
        op = o;
        #1;
    endtask

    // Runs one complete instruction and checks every cycle against the model.
    // When it returns, the DUT should be in FETCH of the next instruction,
    // and the time is 1 unit after that rising edge.
    task automatic runInstr(input logic [6:0] o, input string name);
        logic [15:0] expVec;
        applyStimulus(o);
        for (int i = 0; i < latencyOf(o); i++) begin
            expVec = stepVec(stepAt(o, i));
            totalCount++;
            if (actualVec !== expVec) begin
                badCount++;
                $display("[TB] FAIL %s cycle %0d op=%b: got %h want %h", name, i + 1, o, actualVec, expVec);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        op    = 7'($urandom);
        #1;
        for (int i = 0; i < 4; i++) begin
            totalCount++;
            if (actualVec !== 16'h0000) begin
                badCount++;
                $display("[TB] FAIL reset_hold cycle %0d: got %h want 0000", i, actualVec);
            end
            @(posedge clk);
            #1;
            op = 7'($urandom);
            #1;
        end
        reset = 1'b0;
    endtask

    task automatic test_load();      runInstr(7'b0000011, "load");    endtask
    task automatic test_store();     runInstr(7'b0100011, "store");   endtask
    task automatic test_beq();       runInstr(7'b1100011, "beq");     endtask
    task automatic test_illegal();   runInstr(7'b1111111, "illegal"); endtask
    task automatic test_jalr();      runInstr(7'b1100111, "jalr");    endtask

    task automatic test_alu_jal();
        runInstr(7'b0110011, "rtype");
        runInstr(7'b0010011, "itype");
        runInstr(7'b1101111, "jal");
    endtask

    // Reset is raised during EXECR of an R-type instruction. The instruction
    // must be dropped. The cycle after release must show FETCH, not ALUWB.
    task automatic test_reset_midinstr();
        logic [15:0] expVec;
        op = 7'b0110011;
        #1;
        for (int i = 0; i < 3; i++) begin
            expVec = stepVec(stepAt(7'b0110011, i));
            totalCount++;
            if (actualVec !== expVec) begin
                badCount++;
                $display("[TB] FAIL midreset_pre cycle %0d: got %h want %h", i + 1, actualVec, expVec);
            end
            if (i < 2) begin
                @(posedge clk);
                #1;
            end
        end
        reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            totalCount++;
            if (actualVec !== 16'h0000) begin
                badCount++;
                $display("[TB] FAIL midreset_hold step %0d: got %h want 0000", i, actualVec);
            end
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        runInstr(7'b0110011, "after_reset");
    endtask

    // Random opcodes run back to back. About one third are fully random
    // 7-bit values, so most of those take the illegal path.
    task automatic test_back_to_back();
        logic [6:0] known[8];
        logic [6:0] o;
        known = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                  7'b1101111, 7'b1100011, 7'b1100111, 7'b0000000};
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(2) == 0) o = 7'($urandom);
            else                        o = known[$urandom_range(7)];
            runInstr(o, "random");
        end
    endtask

    initial begin
        reset = 1'b1;
        op    = 7'b0;
        test_reset();
        test_load();
        test_store();
        test_beq();
        test_illegal();
        test_alu_jal();
        test_jalr();
        test_reset_midinstr();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule

// File: doc/multicycle_fsm.md
MULTICYCLE_FSM -- requirements
Module: multicycle_fsm

Interface
REQ-001 Parameters: none; state encoding is fixed by the shared package.
REQ-002 clk  input  1  sole clock; all state updates occur on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 op  input  7  opcode field of the instruction register.
REQ-005 Branch  output  1  branch-qualify strobe to PC-enable logic.
REQ-006 PCUpdate  output  1  unconditional PC write enable.
REQ-007 RegWrite  output  1  register file write enable.
REQ-008 MemWrite  output  1  data memory write enable.
REQ-009 IRWrite  output  1  instruction register and OldPC load enable.
REQ-010 ResultSrc  output  2  result mux select: 00 ALUOut, 01 Data, 10 ALUResult.
REQ-011 ALUSrcA  output  2  ALU A mux select: 00 PC, 01 OldPC, 10 rs1.
REQ-012 ALUSrcB  output  2  ALU B mux select: 00 rs2, 01 immediate, 10 constant 4.
REQ-013 AdrSrc  output  1  memory address select: 0 PC, 1 ALUOut.
REQ-014 ALUOp  output  2  to ALU decoder: 00 add, 01 subtract, 10 decode by funct3/funct7.
REQ-015 instr_done  output  1  one-cycle pulse in the final state of each instruction.
REQ-016 illegal  output  1  one-cycle pulse in DECODE when op is unsupported.

Function
REQ-017 The block SHALL be a Moore FSM; all outputs SHALL decode from the current state only (illegal also uses op in DECODE).
REQ-018 Output signals not listed for a state SHALL be 0 or 00.
REQ-019 FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1; next state DECODE.
REQ-020 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00; next state is MEMADR for op 0000011/0100011, EXECR for 0110011, EXECI for 0010011, JAL for 1101111, BEQ for 1100011, FETCH otherwise with illegal=1.
REQ-021 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00; next state MEMREAD if op=0000011, else MEMWRITE.
REQ-022 MEMREAD: ResultSrc=00, AdrSrc=1; next state MEMWB.
REQ-023 MEMWB: ResultSrc=01, RegWrite=1, instr_done=1; next state FETCH.
REQ-024 MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1, instr_done=1; next state FETCH.
REQ-025 EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10; next state ALUWB.
REQ-026 EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10; next state ALUWB.
REQ-027 ALUWB: ResultSrc=00, RegWrite=1, instr_done=1; next state FETCH.
REQ-028 JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1; next state ALUWB.
REQ-029 BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, instr_done=1; next state FETCH.
REQ-030 Instruction latencies SHALL be: lw 5 cycles, sw 4, R/I-type 4, jal 4, beq 3, illegal 2.
REQ-031 An unreachable state encoding SHALL transition to FETCH with all enables 0.

Reset
REQ-032 With reset high at a rising edge, the next state SHALL be FETCH.
REQ-033 While reset is high, Branch, PCUpdate, RegWrite, MemWrite, IRWrite, instr_done and illegal SHALL be 0, and the select outputs SHALL be 00.
REQ-034 Reset asserted mid-instruction SHALL abandon that instruction; no write enable SHALL assert until FETCH in the first cycle after reset deasserts.

Configuration
REQ-035 With MULTICYCLE_FSM_JALR_EN defined, DECODE SHALL send op 1100111 to JALR1; without the macro, op 1100111 SHALL be treated as illegal.
REQ-036 JALR1: ALUSrcA=10, ALUSrcB=01, ALUOp=00; next state JALR2.
REQ-037 JALR2: ResultSrc=00, PCUpdate=1, ALUSrcA=01, ALUSrcB=10, ALUOp=00; next state ALUWB, giving a total jalr latency of 5 cycles.

Structure
REQ-038 The shared package SHALL hold the state enumeration (4 bits), the opcode constants, the ALUOp encodings and the mux-select encodings.
REQ-039 A single sub-module, multicycle_fsm_outdec, SHALL map state to the control output vector; next-state logic and the state register SHALL remain in multicycle_fsm.

Verification
REQ-040 Release reset, op=0000011 -> states FETCH,DECODE,MEMADR,MEMREAD,MEMWB; RegWrite=1 and ResultSrc=01 only in cycle 5; instr_done in cycle 5.
REQ-041 op=0100011 -> MemWrite=1 and AdrSrc=1 in cycle 4 only; RegWrite never asserts.
REQ-042 op=1100011 -> Branch=1 and ALUOp=01 in cycle 3; FETCH in cycle 4.
REQ-043 op=1111111 -> illegal=1 in DECODE; FETCH in cycle 3; no write enable asserted.
REQ-044 Assert reset during EXECR of op=0110011 -> all enables 0 while reset is high; FETCH outputs appear in the first cycle after release; no ALUWB occurs.
REQ-045 op=1100111 with and without MULTICYCLE_FSM_JALR_EN -> JALR1, JALR2, ALUWB sequence with PCUpdate=1 in JALR2 when defined; illegal=1 in DECODE when not defined.
